// File: rtl/led_share_ctrl.sv
// rtl/led_share_ctrl.sv - LED owner arbiter with button debounce, pattern generator and HPS passthrough
module led_share_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int HEARTBEAT_CYCLES = 25000000,
    parameter int HOLD_CYCLES      = 250000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [1:0] button_n,
    input  logic [3:0] dipsw,
    input  logic [7:0] hps_led,
    output logic [7:0] led,
    output logic [1:0] owner,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press
);

    localparam int DB_W   = (DEBOUNCE_CYCLES  > 2) ? $clog2(DEBOUNCE_CYCLES)  : 1;
    localparam int HB_W   = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES      > 2) ? $clog2(HOLD_CYCLES)      : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        OWN_PATTERN  = 2'b00,
        OWN_HPS      = 2'b01,
        OWN_OVERRIDE = 2'b10
    } owner_t;

    owner_t state, state_next;

    logic [1:0]        sync1, sync2;
    logic [DB_W-1:0]   db_cnt [2];
    logic [HB_W-1:0]   tick_cnt;
    logic              tick;
    logic [7:0]        hps_q;
    logic              act;
    logic [HOLD_W-1:0] idle_cnt;
    logic              hb;
    logic [7:0]        walk;
    logic [7:0]        pat_cnt;
    logic [7:0]        ov;
    logic [7:0]        led_next;
    logic              unused_dipsw;

    assign unused_dipsw = dipsw[2];
    assign owner        = state;
    assign tick         = (tick_cnt == HB_LAST);
    assign act          = (hps_led != hps_q);

    // Two-flop synchronizer; idle level of the buttons is high.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_level <= 2'b11;
            btn_press <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                btn_press[i] <= 1'b0;
                if (sync2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i] <= sync2[i];
                    btn_press[i] <= ~sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tick_cnt <= '0;
            hb       <= 1'b0;
            walk     <= 8'h01;
            pat_cnt  <= 8'h00;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + HB_W'(1);
            if (tick) begin
                hb      <= ~hb;
                walk    <= {walk[6:0], walk[7]};
                pat_cnt <= pat_cnt + 8'd1;
            end
        end
    end

    // Idle counter reloads on every hps_led change, whoever owns the LEDs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hps_q    <= 8'h00;
            idle_cnt <= '0;
        end else begin
            hps_q <= hps_led;
            if (act) begin
                idle_cnt <= HOLD_LAST;
            end else if (idle_cnt != '0) begin
                idle_cnt <= idle_cnt - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= OWN_PATTERN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (dipsw[3]) begin
            state_next = OWN_HPS;
        end else begin
            case (state)
                OWN_PATTERN: begin
                    if (btn_press[0]) state_next = OWN_OVERRIDE;
                    else if (act)     state_next = OWN_HPS;
                end
                OWN_HPS: begin
                    if (btn_press[0])                  state_next = OWN_OVERRIDE;
                    else if (idle_cnt == '0 && !act)   state_next = OWN_PATTERN;
                end
                OWN_OVERRIDE: begin
                    if (btn_press[0]) state_next = OWN_PATTERN;
                end
                default: state_next = OWN_PATTERN;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ov <= 8'h00;
        end else if (state == OWN_OVERRIDE && btn_press[1]) begin
            ov <= ov + 8'd1;
        end
    end

    always_comb begin
        led_next = 8'h00;
        case (state)
            OWN_PATTERN: begin
                case (dipsw[1:0])
                    2'b00:   led_next = {7'b0, hb};
                    2'b01:   led_next = walk;
                    2'b10:   led_next = pat_cnt;
                    default: led_next = 8'h00;
                endcase
            end
            OWN_HPS:      led_next = hps_led;
            OWN_OVERRIDE: led_next = ov;
            default:      led_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            led <= 8'h00;
        end else begin
            led <= led_next;
        end
    end

endmodule
